// File: rtl/cam_frame_sequencer.sv
// cam_frame_sequencer: OV7670 capture framing, RGB444 packing and frame-boundary write-port arbitration.
module cam_frame_sequencer #(
  parameter int HWIDTH = 640,
  parameter int VWIDTH = 480,
  parameter int AWIDTH = 19,
  parameter int DWIDTH = 12
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync_cam,
  input  logic              href_cam,
  input  logic [7:0]        wdata_cam,
  input  logic              proc_req,
  input  logic              proc_done,
  output logic              proc_grant,
  output logic              pix_we,
  output logic [AWIDTH-1:0] pix_addr,
  output logic [DWIDTH-1:0] pix_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);
  localparam int CW = $clog2(HWIDTH + 1);
  localparam int RW = $clog2(VWIDTH + 1);
  localparam logic [CW-1:0] HMAX = CW'(HWIDTH);
  localparam logic [RW-1:0] VMAX = RW'(VWIDTH);
  localparam logic [AWIDTH-1:0] HSTEP = AWIDTH'(HWIDTH);
  typedef enum logic [2:0] {IDLE, VBLANK, WAIT_HREF, B1, B0_NEXT, LEND, FEND} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [3:0] r_b0;
  logic r_grant, r_done, r_first, r_we, r_fs, r_fd, r_err;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_data;
  logic [7:0] r_cnt;
  logic w_end, w_cap, w_we, w_own, w_rel;
  // vsync rising mid-line ends the line exactly like href falling
  assign w_end = vsync_cam || !href_cam;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = vsync_cam ? VBLANK : IDLE;
      VBLANK:    w_next = vsync_cam ? VBLANK : WAIT_HREF;
      WAIT_HREF: w_next = (vsync_cam || r_row == VMAX) ? FEND : href_cam ? B1 : WAIT_HREF;
      B1:        w_next = w_end ? LEND : B0_NEXT;
      B0_NEXT:   w_next = w_end ? LEND : B1;
      LEND:      w_next = WAIT_HREF;
      default:   w_next = IDLE;
    endcase
  end
  assign w_cap = r_state == B1 && !w_end;
  assign w_we  = w_cap && r_col < HMAX && r_row < VMAX && !r_grant;
  assign w_own = r_state == FEND || (r_state == IDLE && r_first);
  assign w_rel = r_grant && (r_done || proc_done) && !proc_req;
  always_ff @(posedge pclk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_b0 <= '0;
      r_grant <= 1'b0;
      r_done <= 1'b0;
      r_first <= 1'b1;
      r_we <= 1'b0;
      r_fs <= 1'b0;
      r_fd <= 1'b0;
      r_err <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_cnt <= '0;
    end else begin
      r_we <= w_we;
      r_fs <= r_state == VBLANK && !vsync_cam;
      r_fd <= r_state == FEND;
      if (w_we) begin
        r_addr <= AWIDTH'(r_row) * HSTEP + AWIDTH'(r_col);
        r_data <= DWIDTH'({r_b0, wdata_cam});
      end
      if ((r_state == WAIT_HREF || r_state == B0_NEXT) && href_cam) r_b0 <= wdata_cam[3:0];
      if (r_state == WAIT_HREF) r_col <= '0;
      if (w_cap && r_col < HMAX) r_col <= r_col + 1'b1;
      if (r_state == VBLANK) r_row <= '0;
      if (r_state == LEND) r_row <= r_row + 1'b1;
      if (r_state == LEND && r_col < HMAX) r_err <= 1'b1;
      if (r_state == FEND && r_row < VMAX) r_err <= 1'b1;
      if (r_state == FEND) r_cnt <= r_cnt + 8'd1;
      if (r_state == IDLE && vsync_cam) r_first <= 1'b0;
      if (proc_done) r_done <= 1'b1;
      // a done pulse coinciding with the boundary counts toward that boundary
      if (w_own) begin
        if (!r_grant && proc_req) r_grant <= 1'b1;
        else if (w_rel) begin
          r_grant <= 1'b0;
          r_done <= 1'b0;
        end
      end
    end
  end
  assign proc_grant  = r_grant;
  assign pix_we      = r_we;
  assign pix_addr    = r_addr;
  assign pix_data    = r_data;
  assign frame_start = r_fs;
  assign frame_done  = r_fd;
  assign frame_err   = r_err;
  assign frame_cnt   = r_cnt;
endmodule

// File: tb/tb_cam_frame_sequencer.sv
// tb_cam_frame_sequencer: frame-level reference model with a per-cycle pixel write scoreboard.
module tb_cam_frame_sequencer;
  localparam int H = 4;
  localparam int V = 4;
  logic pclk = 0, rst = 1, vsync_cam = 0, href_cam = 0, proc_req = 0, proc_done = 0;
  logic [7:0] wdata_cam = 0;
  logic proc_grant, pix_we, frame_start, frame_done, frame_err;
  logic [18:0] pix_addr;
  logic [11:0] pix_data;
  logic [7:0] frame_cnt;
  cam_frame_sequencer #(.HWIDTH(H), .VWIDTH(V), .AWIDTH(19), .DWIDTH(12)) dut (
    .pclk(pclk), .rst(rst), .vsync_cam(vsync_cam), .href_cam(href_cam), .wdata_cam(wdata_cam),
    .proc_req(proc_req), .proc_done(proc_done), .proc_grant(proc_grant), .pix_we(pix_we),
    .pix_addr(pix_addr), .pix_data(pix_data), .frame_start(frame_start), .frame_done(frame_done),
    .frame_err(frame_err), .frame_cnt(frame_cnt));
  always #5 pclk = ~pclk;
  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t q[$];
  int cyc_n = 0, n_tests = 0, n_fail = 0, n_fd = 0, n_fs = 0, n_we = 0, last_addr = 0, last_data = 0;
  bit m_grant = 0, m_done = 0, m_err = 0, fixed = 0;
  int m_cnt = 0;
  always @(posedge pclk) cyc_n <= cyc_n + 1;
  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction
  always @(negedge pclk) begin
    wr_t e;
    while (q.size() > 0 && q[0].cyc < cyc_n) begin
      n_tests++;
      n_fail++;
      $display("FAIL missed_write: addr %0d due at cycle %0d", q[0].addr, q[0].cyc);
      void'(q.pop_front());
    end
    if (frame_done) n_fd++;
    if (frame_start) n_fs++;
    if (pix_we) begin
      n_we++;
      last_addr = int'(pix_addr);
      last_data = int'(pix_data);
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected", pix_addr, pix_data);
      end else begin
        e = q.pop_front();
        chk("write_cycle", cyc_n, e.cyc);
        chk("write_addr", int'(pix_addr), e.addr);
        chk("write_data", int'(pix_data), e.data);
      end
    end
  end
  task automatic drv(input logic v, input logic h, input logic [7:0] d);
    vsync_cam = v;
    href_cam = h;
    wdata_cam = d;
    @(posedge pclk);
    #1;
  endtask
  task automatic pix(input int row, input int p);
    logic [7:0] b0, b1;
    b0 = fixed ? 8'h0A : 8'($urandom);
    b1 = fixed ? 8'hBC : 8'($urandom);
    drv(0, 1, b0);
    if (p < H && row < V && !m_grant) q.push_back('{cyc_n + 1, row * H + p, int'({b0[3:0], b1})});
    drv(0, 1, b1);
  endtask
  task automatic send_line(input int row, input int npix, input bit odd);
    for (int p = 0; p < npix; p++) pix(row, p);
    if (odd) drv(0, 1, 8'($urandom));
    repeat (3) drv(0, 0, 0);
  endtask
  // mode: 1 done pulse mid-frame, 2 done pulse on the boundary cycle, 3 req blip, 4 raise req, 5 drop req
  task automatic frame(input int nl, input int lens[6], input int odd_mask, input int mode, input int vcut);
    int fd0 = n_fd;
    int fs0 = n_fs;
    bit ferr = (nl < V);
    repeat (2) drv(0, 0, 0);
    for (int l = 0; l < nl; l++) begin
      send_line(l, lens[l], odd_mask[l]);
      if (l < V && lens[l] < H) ferr = 1;
      if (l == 0) begin
        if (mode == 1) begin
          proc_done = 1;
          m_done = 1;
          drv(0, 0, 0);
          proc_done = 0;
        end
        if (mode == 3) begin
          proc_req = !proc_req;
          repeat (2) drv(0, 0, 0);
          proc_req = !proc_req;
        end
        if (mode == 4) proc_req = 1;
        if (mode == 5) proc_req = 0;
      end
    end
    if (vcut >= 0) begin
      for (int p = 0; p < vcut; p++) pix(nl, p);
      repeat (4) drv(1, 1, 8'($urandom));
    end
    drv(1, 0, 0);
    if (mode == 2) begin
      proc_done = 1;
      m_done = 1;
    end
    drv(1, 0, 0);
    proc_done = 0;
    repeat (2) drv(1, 0, 0);
    m_cnt = (m_cnt + 1) % 256;
    m_err = m_err | ferr;
    if (!m_grant && proc_req) m_grant = 1;
    else if (m_grant && m_done && !proc_req) begin
      m_grant = 0;
      m_done = 0;
    end
    chk("frame_done_count", n_fd - fd0, 1);
    chk("frame_start_count", n_fs - fs0, 1);
    chk("frame_cnt", int'(frame_cnt), m_cnt);
    chk("frame_err", int'(frame_err), int'(m_err));
    chk("proc_grant", int'(proc_grant), int'(m_grant));
    chk("writes_pending", q.size(), 0);
  endtask
  task automatic chk_reset();
    chk("rst_proc_grant", int'(proc_grant), 0);
    chk("rst_pix_we", int'(pix_we), 0);
    chk("rst_pix_addr", int'(pix_addr), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
  endtask
  initial begin
    int full[6] = '{4, 4, 4, 4, 0, 0};
    int lens[6];
    int we0, fd0, nl, mode, vcut;
    repeat (3) drv(0, 0, 0);
    chk_reset();
    rst = 0;
    repeat (4) drv(1, 0, 0);
    fixed = 1;
    frame(4, full, 0, 0, -1);
    fixed = 0;
    chk("t1_write_count", n_we, 16);
    chk("t1_last_addr", last_addr, 15);
    chk("t1_last_data", last_data, 'hABC);
    chk("t1_frame_cnt", int'(frame_cnt), 1);
    chk("t1_frame_err", int'(frame_err), 0);
    frame(4, '{4, 4, 3, 4, 0, 0}, 0, 0, -1);
    chk("t2_frame_err", int'(frame_err), 1);
    chk("t2_last_addr", last_addr, 15);
    frame(4, full, 0, 4, -1);
    chk("t3_grant", int'(proc_grant), 1);
    we0 = n_we;
    frame(4, full, 0, 1, -1);
    chk("t3_no_writes", n_we - we0, 0);
    chk("t3_frame_cnt", int'(frame_cnt), 4);
    chk("t4_grant_held", int'(proc_grant), 1);
    frame(4, full, 0, 5, -1);
    chk("t4_released", int'(proc_grant), 0);
    frame(4, full, 0, 0, -1);
    proc_req = 1;
    frame(4, full, 0, 0, -1);
    chk("t4_regrant", int'(proc_grant), 1);
    proc_req = 0;
    frame(2, full, 0, 2, -1);
    chk("t4_fend_done_release", int'(proc_grant), 0);
    frame(4, '{4, 6, 4, 4, 0, 0}, 0, 0, -1);
    repeat (2) drv(0, 0, 0);
    send_line(0, 4, 0);
    pix(1, 0);
    rst = 1;
    drv(0, 1, 8'($urandom));
    chk_reset();
    rst = 0;
    q.delete();
    m_cnt = 0;
    m_err = 0;
    m_grant = 0;
    m_done = 0;
    we0 = n_we;
    fd0 = n_fd;
    repeat (8) drv(0, 1, 8'($urandom));
    repeat (3) drv(0, 0, 0);
    repeat (4) drv(1, 0, 0);
    chk("t6_no_writes_after_abort", n_we - we0, 0);
    chk("t6_no_frame_done_after_abort", n_fd - fd0, 0);
    fixed = 1;
    frame(4, full, 0, 0, -1);
    fixed = 0;
    chk("t6_writes_after_restart", n_we - we0, 16);
    chk("t6_frame_cnt", int'(frame_cnt), 1);
    for (int f = 0; f < 30; f++) begin
      nl = $urandom_range(1, 5);
      for (int i = 0; i < 6; i++) lens[i] = $urandom_range(1, 6);
      vcut = (nl < V && $urandom_range(0, 2) == 0) ? $urandom_range(0, 2) : -1;
      mode = $urandom_range(0, 5);
      if (mode == 2 && (nl >= V || vcut >= 0)) mode = 0;
      if ($urandom_range(0, 2) == 0) proc_req = !proc_req;
      frame(nl, lens, int'($urandom), mode, vcut);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
